pio_pattern_seq: RTL



---
 rtl/pio_pattern_seq_if.sv | 11 +
 rtl/pio_pattern_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pio_pattern_seq_if.sv
// Avalon-MM slave register bus for the pattern-sequencer PIO.
interface pio_pattern_seq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_pattern_seq.sv
// Output PIO with direct/OUTSET/OUTCLEAR writes and an autonomous pattern-table sequencer.
module pio_pattern_seq #(
  parameter int unsigned               DATA_WIDTH     = 3,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE    = '0,
  parameter int unsigned               NUM_STEPS      = 4,
  parameter int unsigned               PRESCALE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_pattern_seq_if.slave      avs,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int unsigned IW  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned DUR = 16;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_IDX    = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;
  localparam logic [2:0] A_STEP   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      loop_q, loop_d;
  logic                      irq_en_q, irq_en_d;
  logic [PRESCALE_WIDTH-1:0] period_q, period_d;
  logic [IW-1:0]             step_idx_q, step_idx_d;
  logic [IW-1:0]             cur_step_q, cur_step_d;
  logic                      done_q, done_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [DUR-1:0]            dur_cnt_q, dur_cnt_d;
  logic                      irq_q;
  logic [DATA_WIDTH-1:0]     pat_q [NUM_STEPS];
  logic [DATA_WIDTH-1:0]     pat_d [NUM_STEPS];
  logic [DUR-1:0]            dur_q [NUM_STEPS];
  logic [DUR-1:0]            dur_d [NUM_STEPS];

  logic [31:0]   wd_c;
  logic          wr_c;
  logic          busy_c;
  logic          load_c;
  logic [IW-1:0] load_idx_c;
  logic [31:0]   rdata_c;
  logic          unused_c;

  assign wd_c     = avs.writedata;
  assign wr_c     = avs.chipselect & ~avs.write_n;
  assign busy_c   = (state_q == S_RUN);
  assign unused_c = ^wd_c;

  // Next-state: register writes, sequencer stepping, and step loading.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    step_idx_d = step_idx_q;
    cur_step_d = cur_step_q;
    done_d     = done_q;
    presc_d    = presc_q;
    dur_cnt_d  = dur_cnt_q;
    pat_d      = pat_q;
    dur_d      = dur_q;
    load_c     = 1'b0;
    load_idx_c = '0;

    if (wr_c && avs.address == A_IDX) step_idx_d = wd_c[IW-1:0];
    if (wr_c && avs.address == A_STEP) begin
      pat_d[step_idx_q] = wd_c[DATA_WIDTH-1:0];
      dur_d[step_idx_q] = wd_c[31:16];
      step_idx_d        = step_idx_q + IW'(1);
    end
    if (wr_c && avs.address == A_PERIOD) period_d = wd_c[PRESCALE_WIDTH-1:0];
    if (wr_c && avs.address == A_STATUS && wd_c[1]) done_d = 1'b0;
    if (wr_c && avs.address == A_CTRL) begin
      loop_d   = wd_c[1];
      irq_en_d = wd_c[2];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_c && avs.address == A_DATA) data_d = wd_c[DATA_WIDTH-1:0];
        if (wr_c && avs.address == A_SET)  data_d = data_q | wd_c[DATA_WIDTH-1:0];
        if (wr_c && avs.address == A_CLR)  data_d = data_q & ~wd_c[DATA_WIDTH-1:0];
        if (wr_c && avs.address == A_CTRL && wd_c[0]) begin
          state_d = S_RUN;
          presc_d = period_q;
          done_d  = 1'b0;
          load_c  = 1'b1;
        end
      end
      S_RUN: begin
        // A CTRL write overrides any step advance in the same cycle.
        if (wr_c && avs.address == A_CTRL) begin
          if (wd_c[0]) begin
            presc_d = period_q;
            load_c  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (presc_q == '0) begin
          presc_d = period_q;
          if (dur_cnt_q == DUR'(1)) begin
            if (cur_step_q != IW'(NUM_STEPS - 1)) begin
              load_c     = 1'b1;
              load_idx_c = cur_step_q + IW'(1);
            end else if (loop_q) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - DUR'(1);
          end
        end else begin
          presc_d = presc_q - PRESCALE_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A zero duration in the table behaves as one tick.
    if (load_c) begin
      cur_step_d = load_idx_c;
      data_d     = pat_q[load_idx_c];
      dur_cnt_d  = (dur_q[load_idx_c] == '0) ? DUR'(1) : dur_q[load_idx_c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      data_q     <= RESET_VALUE;
      loop_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= '0;
      step_idx_q <= '0;
      cur_step_q <= '0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      dur_cnt_q  <= '0;
      irq_q      <= 1'b0;
      pat_q      <= '{default: '0};
      dur_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      loop_q     <= loop_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      step_idx_q <= step_idx_d;
      cur_step_q <= cur_step_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      dur_cnt_q  <= dur_cnt_d;
      irq_q      <= done_d & irq_en_d;
      pat_q      <= pat_d;
      dur_q      <= dur_d;
    end
  end

  // Zero-wait-state read mux; no read side effects.
  always_comb begin
    rdata_c = '0;
    case (avs.address)
      A_DATA:   rdata_c = 32'(data_q);
      A_CTRL:   rdata_c = 32'({irq_en_q, loop_q, busy_c});
      A_PERIOD: rdata_c = 32'(period_q);
      A_IDX:    rdata_c = 32'(step_idx_q);
      A_STEP:   rdata_c = {dur_q[step_idx_q], 16'(pat_q[step_idx_q])};
      A_STATUS: rdata_c = {20'd0, 4'(cur_step_q), 6'd0, done_q, busy_c};
      default:  rdata_c = '0;
    endcase
  end

  assign avs.readdata = rdata_c;
  assign out_port     = data_q;
  assign irq          = irq_q;

endmodule
